// File: rtl/edge_window_sequencer.sv
// Raster 3x3 window builder: two line buffers feed a sliding window for an external edge
// detector, and its 2-bit results are queued in a small output FIFO.
module edge_window_sequencer #(
  parameter int unsigned IMG_W     = 160,
  parameter int unsigned IMG_H     = 120,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [3:0]            pixIn,
  input  logic                  pixValid,
  output logic                  pixReady,
  output logic [2:0][2:0][3:0]  pixelData,
  output logic                  inputValid,
  input  logic [1:0]            edgeVal,
  input  logic                  edgeValValid,
  output logic [1:0]            outPix,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  frameDone
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam int unsigned NW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [2:0][2:0][3:0] win_q, win_d;
  logic                 iv_q, iv_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic [1:0]           fifo_q [OUT_DEPTH];
  logic [3:0]           lba_q [IMG_W];
  logic [3:0]           lbb_q [IMG_W];

  logic          accept, push, pop, last_col, last_pix;
  logic [NW:0]   occupancy;

  // Results still in flight through the window count against FIFO space; pops are not credited.
  assign occupancy = {1'b0, count_q} + {{NW{1'b0}}, iv_q};
  assign pixReady  = (state_q == StRun) && (occupancy < (NW + 1)'(OUT_DEPTH));
  assign accept    = pixValid && pixReady;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_pix  = last_col && (row_q == RW'(IMG_H - 1));
  assign push      = edgeValValid;
  assign pop       = outValid && outReady;

  assign pixelData  = win_q;
  assign inputValid = iv_q;
  assign outValid   = (count_q != '0);
  assign outPix     = fifo_q[rd_ptr_q];
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    iv_d      = 1'b0;
    frameDone = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
          win_d[0][2] = lba_q[col_q];
          win_d[1][2] = lbb_q[col_q];
          win_d[2][2] = pixIn;
          iv_d        = (row_q >= RW'(2)) && (col_q >= CW'(2));
          if (last_pix) begin
            state_d = StDrain;
            col_d   = '0;
            row_d   = '0;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (count_q == '0 && !iv_q) begin
          state_d   = StIdle;
          frameDone = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
      iv_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
      iv_q     <= iv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) fifo_q[wr_ptr_q] <= edgeVal;
    end
  end

  // Line buffers hold no state that matters across reset, so they are left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lba_q[col_q] <= lbb_q[col_q];
      lbb_q[col_q] <= pixIn;
    end
  end

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Randomized bench for edge_window_sequencer: emulates the edge detector and checks windows
// and results against frame-level expectations built from a stored image.
module tb_edge_window_sequencer;

  localparam int W = 5;
  localparam int H = 4;
  localparam int D = 4;

  logic                 clk = 1'b0;
  logic                 nreset = 1'b0;
  logic                 start = 1'b0;
  logic [3:0]           pixIn = '0;
  logic                 pixValid = 1'b0;
  logic                 pixReady;
  logic [2:0][2:0][3:0] pixelData;
  logic                 inputValid;
  logic [1:0]           edgeVal;
  logic                 edgeValValid;
  logic [1:0]           outPix;
  logic                 outValid;
  logic                 outReady = 1'b0;
  logic                 busy;
  logic                 frameDone;

  int          n_checks = 0;
  int          n_errs = 0;
  int          fr [H][W];
  logic [1:0]  exp_q [$];

  always #5 clk = ~clk;

  edge_window_sequencer #(
    .IMG_W    (W),
    .IMG_H    (H),
    .OUT_DEPTH(D)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .start       (start),
    .pixIn       (pixIn),
    .pixValid    (pixValid),
    .pixReady    (pixReady),
    .pixelData   (pixelData),
    .inputValid  (inputValid),
    .edgeVal     (edgeVal),
    .edgeValValid(edgeValValid),
    .outPix      (outPix),
    .outValid    (outValid),
    .outReady    (outReady),
    .busy        (busy),
    .frameDone   (frameDone)
  );

  // Sobel magnitude quantised to 2 bits; stands in for the edgeDetect datapath.
  function automatic logic [1:0] sobel(input logic [2:0][2:0][3:0] w);
    int p [3][3];
    int gx, gy, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) p[i][j] = int'(w[i][j]);
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m == 0) return 2'd0;
    if (m < 16) return 2'd1;
    if (m < 48) return 2'd2;
    return 2'd3;
  endfunction

  assign edgeVal      = inputValid ? sobel(pixelData) : 2'd0;
  assign edgeValValid = inputValid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0][2:0][3:0] window_at(input int r, input int c);
    logic [2:0][2:0][3:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w[i][j] = 4'(fr[r - 1 + i][c - 1 + j]);
    return w;
  endfunction

  task automatic gen_frame(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       fr[r][c] = 0;
          1:       fr[r][c] = (r * 5 + c) & 15;
          2:       fr[r][c] = (c < 2) ? 0 : 15;
          default: fr[r][c] = int'($urandom_range(0, 15));
        endcase
    exp_q.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) exp_q.push_back(sobel(window_at(r, c)));
  endtask

  function automatic logic [63:0] all_outputs();
    return {pixReady, inputValid, outValid, outPix, busy, frameDone, pixelData};
  endfunction

  // rdy_mode: 0 always ready, 1 held low until stall then ready, 2 random.
  task automatic run_frame(input int rdy_mode, input bit rnd_valid, input bit rnd_start,
                           input int abort_after);
    int acc = 0, win_k = 0, cyc = 0, stall_at = 0, n_int = 0;
    bit done = 1'b0, dropped = 1'b0;
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx / W >= 2 && idx % W >= 2) n_int++;
      if (n_int == D && stall_at == 0) stall_at = idx + 1;
    end
    start = 1'b1;
    pixValid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_run", busy, 1);
    while (!done && cyc < 2000) begin
      if (inputValid) begin
        check("window", pixelData, window_at(1 + win_k / (W - 2), 1 + win_k % (W - 2)));
        win_k++;
      end
      if (frameDone) begin
        check("done_fifo_drained", exp_q.size(), 0);
        check("done_all_accepted", acc, W * H);
        done = 1'b1;
      end
      if (abort_after > 0 && acc == abort_after) begin
        nreset = 1'b0;
        #1;
        check("abort_outputs", all_outputs(), 0);
        @(posedge clk); #1;
        check("abort_idle", all_outputs(), 0);
        nreset = 1'b1;
        pixValid = 1'b0;
        outReady = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        return;
      end
      pixValid = (acc < W * H) && (rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
      pixIn    = (acc < W * H) ? 4'(fr[acc / W][acc % W]) : 4'd0;
      case (rdy_mode)
        0: outReady = 1'b1;
        1: begin
          outReady = (cyc >= 40);
          if (cyc == 40) begin
            check("stall_ready_low", pixReady, 0);
            check("stall_accepted", acc, stall_at);
            check("stall_out_valid", outValid, 1);
          end
        end
        default: outReady = ($urandom_range(0, 2) != 0);
      endcase
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rdy_mode == 0 && !rnd_valid && acc < W * H && !pixReady) dropped = 1'b1;
      if (pixValid && pixReady) acc++;
      if (outValid && outReady) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else check("outPix", outPix, exp_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    pixValid = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    check("busy_fall", busy, 0);
    check("done_single", frameDone, 0);
    if (rdy_mode == 0 && !rnd_valid) check("ready_steady", dropped, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    nreset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);

    gen_frame(0); run_frame(0, 1'b0, 1'b0, 0);
    gen_frame(1); run_frame(0, 1'b1, 1'b0, 0);
    gen_frame(1); run_frame(1, 1'b0, 1'b0, 0);
    gen_frame(2); run_frame(2, 1'b1, 1'b0, 0);
    gen_frame(3); run_frame(2, 1'b1, 1'b1, 0);
    gen_frame(3); run_frame(0, 1'b1, 1'b0, 0);
    gen_frame(3); run_frame(0, 1'b0, 1'b0, 9);
    gen_frame(3); run_frame(0, 1'b0, 1'b0, 0);
    repeat (4) begin
      gen_frame(3);
      run_frame(2, 1'b1, 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
